// File: rtl/free_buffer_reclaimer_pkg.sv
// Shared types and helpers for the free-buffer reclaimer: FSM encoding,
// counter width and buffer-ID range check.
package free_buffer_reclaimer_pkg;

  typedef enum logic [1:0] {
    RELAY = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width needed to count 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic logic id_in_range(input logic [63:0] id, input int len);
    return id < 64'($unsigned(len));
  endfunction

endpackage

// File: rtl/free_buffer_reclaimer_id_bitmap.sv
// Per-ID "held by a consumer" bitmap with two test ports, one set and one
// clear port; a set and a clear of the same ID in one cycle leaves it set.
module free_buffer_reclaimer_id_bitmap #(
  parameter int N  = 32,
  parameter int IW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] chk_idx,
  output logic          chk_held,
  input  logic          set_en,
  input  logic [IW-1:0] set_idx,
  output logic          set_held,
  input  logic          clr_en,
  input  logic [IW-1:0] clr_idx
);

  logic [N-1:0] bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits <= '0;
    end else begin
      if (clr_en) bits[clr_idx] <= 1'b0;
      if (set_en) bits[set_idx] <= 1'b1;
    end
  end

  assign chk_held = bits[chk_idx];
  assign set_held = bits[set_idx];

endmodule

// File: rtl/free_buffer_reclaimer.sv
// Return-side companion of the free-buffer-ID pool: validates released IDs
// against a held bitmap, forwards legal ones to the pool and tracks drain.
module free_buffer_reclaimer
  import free_buffer_reclaimer_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int INIT_LENGTH = 32,
  localparam int CW = cnt_w(INIT_LENGTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_empty_n,
  output logic                  in_read,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  out_full_n,
  output logic                  out_write,
  output logic [DATA_WIDTH-1:0] out_din,
  input  logic                  alloc_valid,
  input  logic [DATA_WIDTH-1:0] alloc_id,
  input  logic                  drain_req,
  output logic                  drain_done,
  output logic                  double_free,
  output logic                  bad_id,
  output state_t                dbg_state,
  output logic [CW-1:0]         dbg_outstanding
);

  localparam int IW = (INIT_LENGTH > 1) ? $clog2(INIT_LENGTH) : 1;

  // Streams: in_read pops the return FIFO head in the same cycle it is
  // high; out_write holds out_din until the cycle out_full_n is also high.
  state_t        state;
  logic [CW-1:0] outstanding;
  logic          out_vld;

  logic          ret_in_range, alloc_in_range;
  logic          ret_held, alloc_held;
  logic          ret_ok, alloc_ok, alloc_freed, drain_complete;
  logic [IW-1:0] ret_idx, alloc_idx;

  assign ret_idx        = in_dout[IW-1:0];
  assign alloc_idx      = alloc_id[IW-1:0];
  assign ret_in_range   = id_in_range(64'(in_dout), INIT_LENGTH);
  assign alloc_in_range = id_in_range(64'(alloc_id), INIT_LENGTH);

  assign in_read = !reset && in_empty_n && (!out_vld || out_full_n) && (state != DONE);

  assign ret_ok = in_read && ret_in_range && ret_held;
  // An ID freed by this cycle's return may be re-allocated in the same cycle.
  assign alloc_freed = ret_ok && (ret_idx == alloc_idx);
  assign alloc_ok    = alloc_valid && alloc_in_range && (!alloc_held || alloc_freed);

  assign drain_complete = (outstanding == '0) && !out_vld && !alloc_valid;

  free_buffer_reclaimer_id_bitmap #(
    .N  (INIT_LENGTH),
    .IW (IW)
  ) u_bitmap (
    .clk      (clk),
    .rst      (reset),
    .chk_idx  (ret_idx),
    .chk_held (ret_held),
    .set_en   (alloc_ok),
    .set_idx  (alloc_idx),
    .set_held (alloc_held),
    .clr_en   (ret_ok),
    .clr_idx  (ret_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld <= 1'b0;
      out_din <= '0;
    end else if (ret_ok) begin
      out_vld <= 1'b1;
      out_din <= in_dout;
    end else if (out_vld && out_full_n) begin
      out_vld <= 1'b0;
    end
  end

  assign out_write = out_vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({alloc_ok, ret_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      double_free <= 1'b0;
      bad_id      <= 1'b0;
    end else begin
      if ((in_read && !ret_in_range) || (alloc_valid && !alloc_in_range))
        bad_id <= 1'b1;
      if ((in_read && ret_in_range && !ret_held) ||
          (alloc_valid && alloc_in_range && alloc_held && !alloc_freed))
        double_free <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RELAY;
      drain_done <= 1'b0;
    end else begin
      case (state)
        RELAY: begin
          if (drain_req) state <= DRAIN;
          drain_done <= 1'b0;
        end
        DRAIN: begin
          if (!drain_req) begin
            state <= RELAY;
          end else if (drain_complete) begin
            state      <= DONE;
            drain_done <= 1'b1;
          end
        end
        DONE: begin
          if (!drain_req) begin
            state      <= RELAY;
            drain_done <= 1'b0;
          end else if (alloc_valid) begin
            state      <= DRAIN;
            drain_done <= 1'b0;
          end
        end
        default: begin
          state      <= RELAY;
          drain_done <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state       = state;
  assign dbg_outstanding = outstanding;

endmodule
